output_config_regs: RTL

Parametrised configuration register bank for the LED output channels. It replaces the fixed 3-channel, directly written register arrays at the top level. It decodes SPI word writes in the 0xFFxx space into per-channel shadow registers. Shadow values reach the active outputs that drive the apa102_out instances only on a commit, and only at a channel's frame boundary, so parameters never change mid-frame. It also provides registered readback of the shadow state.

---
 rtl/output_config_regs.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/output_config_regs.sv
// Configuration register bank for the LED output channels.
// SPI word writes in the 0xFFxx page land in per-channel shadow registers;
// shadows move to the active outputs only on a commit, and only at the
// channel's frame boundary (or immediately if the channel is disabled or
// the commit is forced). Shadow state can be read back through a single
// registered stage.
module output_config_regs #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int DATA_BUS_WIDTH    = 16,
  parameter int OUTPUT_COUNT      = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDRESS_BUS_WIDTH-1:0]   write_address,
  input  logic [DATA_BUS_WIDTH-1:0]      write_data,
  input  logic                           write_strobe,
  input  logic [ADDRESS_BUS_WIDTH-1:0]   read_address,
  input  logic                           read_strobe,
  output logic [DATA_BUS_WIDTH-1:0]      read_data,
  output logic                           read_valid,
  input  logic [OUTPUT_COUNT-1:0]        frame_done,
  output logic [16*OUTPUT_COUNT-1:0]     word_counts,
  output logic [16*OUTPUT_COUNT-1:0]     start_addresses,
  output logic [2*OUTPUT_COUNT-1:0]      clock_divisors,
  output logic [8*OUTPUT_COUNT-1:0]      page_counts,
  output logic [OUTPUT_COUNT-1:0]        pixel_scales,
  output logic [OUTPUT_COUNT-1:0]        enables,
  output logic [OUTPUT_COUNT-1:0]        commit_pending
);

  // Address split: base selects the register group, offset the channel.
  logic [11:0] wr_base, rd_base;
  logic [3:0]  wr_off, rd_off;
  logic [15:0] wr_word;

  assign wr_base = write_address[15:4];
  assign wr_off  = write_address[3:0];
  assign rd_base = read_address[15:4];
  assign rd_off  = read_address[3:0];
  assign wr_word = write_data[15:0];

  logic wr_wc, wr_sa, wr_div, wr_pc, wr_ps, wr_en, wr_req, wr_force;

  assign wr_wc    = write_strobe && (wr_base == 12'hFF0);
  assign wr_sa    = write_strobe && (wr_base == 12'hFF1);
  assign wr_div   = write_strobe && (wr_base == 12'hFF3);
  assign wr_pc    = write_strobe && (wr_base == 12'hFF4);
  assign wr_ps    = write_strobe && (wr_base == 12'hFF5);
  assign wr_en    = write_strobe && (wr_base == 12'hFF2) && (wr_off == 4'h0);
  assign wr_req   = write_strobe && (wr_base == 12'hFF6) && (wr_off == 4'h0);
  assign wr_force = write_strobe && (wr_base == 12'hFF6) && (wr_off == 4'h1);

  // Shadow values exported per channel for the readback mux.
  logic [15:0]             sh_wc  [OUTPUT_COUNT];
  logic [15:0]             sh_sa  [OUTPUT_COUNT];
  logic [1:0]              sh_div [OUTPUT_COUNT];
  logic [7:0]              sh_pc  [OUTPUT_COUNT];
  logic                    sh_ps  [OUTPUT_COUNT];
  logic [OUTPUT_COUNT-1:0] enables_q;

  // Enables are not shadowed: a write lands on the very next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      enables_q <= '0;
    end else if (wr_en) begin
      enables_q <= write_data[OUTPUT_COUNT-1:0];
    end
  end

  assign enables = enables_q;

  genvar gi;
  generate
    for (gi = 0; gi < OUTPUT_COUNT; gi++) begin : g_ch
      logic [15:0] wc_sh_q, sa_sh_q, wc_q, sa_q;
      logic [1:0]  div_sh_q, div_q;
      logic [7:0]  pc_sh_q, pc_q;
      logic        ps_sh_q, ps_q;
      logic        pend_q, pend_d;
      logic        hit, copy;

      assign hit  = (wr_off == 4'(gi));
      // A disabled channel has no frames, so its commit need not wait.
      assign copy = (pend_q && (frame_done[gi] || !enables_q[gi])) ||
                    (wr_force && write_data[gi]);

      // A new request re-arms pending even on the edge that consumes the old one.
      always_comb begin
        pend_d = (pend_q && !copy) || (wr_req && write_data[gi]);
      end

      // Shadow writes and active copies; the copy sees the pre-edge shadow.
      always_ff @(posedge clk) begin
        if (rst) begin
          wc_sh_q  <= 16'h0000;
          sa_sh_q  <= 16'h0000;
          div_sh_q <= 2'd0;
          pc_sh_q  <= 8'd1;
          ps_sh_q  <= 1'b0;
          wc_q     <= 16'h0000;
          sa_q     <= 16'h0000;
          div_q    <= 2'd0;
          pc_q     <= 8'd1;
          ps_q     <= 1'b0;
          pend_q   <= 1'b0;
        end else begin
          if (wr_wc  && hit) wc_sh_q  <= wr_word;
          if (wr_sa  && hit) sa_sh_q  <= wr_word;
          if (wr_div && hit) div_sh_q <= wr_word[1:0];
          if (wr_pc  && hit) pc_sh_q  <= wr_word[7:0];
          if (wr_ps  && hit) ps_sh_q  <= wr_word[0];
          if (copy) begin
            wc_q  <= wc_sh_q;
            sa_q  <= sa_sh_q;
            div_q <= div_sh_q;
            pc_q  <= pc_sh_q;
            ps_q  <= ps_sh_q;
          end
          pend_q <= pend_d;
        end
      end

      assign word_counts[16*gi +: 16]     = wc_q;
      assign start_addresses[16*gi +: 16] = sa_q;
      assign clock_divisors[2*gi +: 2]    = div_q;
      assign page_counts[8*gi +: 8]       = pc_q;
      assign pixel_scales[gi]             = ps_q;
      assign commit_pending[gi]           = pend_q;

      assign sh_wc[gi]  = wc_sh_q;
      assign sh_sa[gi]  = sa_sh_q;
      assign sh_div[gi] = div_sh_q;
      assign sh_pc[gi]  = pc_sh_q;
      assign sh_ps[gi]  = ps_sh_q;
    end
  endgenerate

  logic [DATA_BUS_WIDTH-1:0] read_data_q, read_data_d;
  logic                      read_valid_q;
  logic [15:0]               sel_wc, sel_sa;
  logic [1:0]                sel_div;
  logic [7:0]                sel_pc;
  logic                      sel_ps, sel_ok;

  // Readback mux; out-of-range channels fall through to zero.
  always_comb begin
    sel_wc  = '0;
    sel_sa  = '0;
    sel_div = '0;
    sel_pc  = '0;
    sel_ps  = 1'b0;
    sel_ok  = 1'b0;
    for (int i = 0; i < OUTPUT_COUNT; i++) begin
      if (rd_off == 4'(i)) begin
        sel_wc  = sh_wc[i];
        sel_sa  = sh_sa[i];
        sel_div = sh_div[i];
        sel_pc  = sh_pc[i];
        sel_ps  = sh_ps[i];
        sel_ok  = 1'b1;
      end
    end
    read_data_d = '0;
    case (rd_base)
      12'hFF0: if (sel_ok) read_data_d = DATA_BUS_WIDTH'(sel_wc);
      12'hFF1: if (sel_ok) read_data_d = DATA_BUS_WIDTH'(sel_sa);
      12'hFF3: if (sel_ok) read_data_d = DATA_BUS_WIDTH'(sel_div);
      12'hFF4: if (sel_ok) read_data_d = DATA_BUS_WIDTH'(sel_pc);
      12'hFF5: if (sel_ok) read_data_d = DATA_BUS_WIDTH'(sel_ps);
      12'hFF2: if (rd_off == 4'h0) read_data_d = DATA_BUS_WIDTH'(enables_q);
      12'hFF6: begin
        if (rd_off == 4'h1) read_data_d = DATA_BUS_WIDTH'(commit_pending);
        if (rd_off == 4'h2) read_data_d = DATA_BUS_WIDTH'(OUTPUT_COUNT);
      end
      default: ;
    endcase
  end

  // Single readback stage; data holds between requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_valid_q <= read_strobe;
      if (read_strobe) read_data_q <= read_data_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;

endmodule
